// File: rtl/spi_proto_pkg.sv
// Shared constants for the 8-byte host/slave command protocol.
// Also holds the helper that turns a cycle count into a down-counter reload value.
package spi_proto_pkg;

  localparam int FRAME_BYTES = 8;

  typedef enum logic [7:0] {
    OP_NOP         = 8'h00,
    OP_INIT        = 8'h01,
    OP_WR_INVERTED = 8'h02,
    OP_WR_LEDS     = 8'h04,
    OP_WR_VEC      = 8'h06,
    OP_RD_VEC      = 8'h07
  } opcode_e;

  localparam logic [7:0] INIT_BYTE   = 8'h11;
  localparam logic [7:0] ECHO_MARKER = 8'h40;

  // A state that must last n cycles reloads n-1 and leaves when the counter reads 0.
  function automatic logic [7:0] div_load(input int unsigned n);
    return 8'(n - 1);
  endfunction

endpackage

// File: rtl/spi_cmd_master_if.sv
// Command-side handshake between a host and spi_cmd_master.
// The host holds the master modport; the SPI engine holds the slave modport.
interface spi_cmd_master_if #(
  parameter int FRAME_BYTES = spi_proto_pkg::FRAME_BYTES
);
  logic                         start;
  logic [7:0]                   opcode;
  logic [8*(FRAME_BYTES-1)-1:0] payload;
  logic                         busy;
  logic                         done;
  logic [8*FRAME_BYTES-1:0]     rx_frame;

  modport master (output start, opcode, payload, input busy, done, rx_frame);
  modport slave  (input start, opcode, payload, output busy, done, rx_frame);
endinterface

// File: rtl/spi_byte_shifter.sv
// 8-bit LSB-first shifter: MOSI is bit 0 of the TX register, MISO enters at bit 7.
// bit_cnt advances with each TX shift and wraps 7->0 at the byte boundary.
module spi_byte_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       sample,
  input  logic       shift,
  input  logic       miso,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic [2:0] bit_cnt
);

  logic [7:0] tx_sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_sr   <= 8'h00;
      rx_byte <= 8'h00;
      bit_cnt <= 3'd0;
    end else begin
      if (load) begin
        tx_sr   <= load_byte;
        bit_cnt <= 3'd0;
      end else if (shift) begin
        tx_sr   <= {1'b0, tx_sr[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (sample)
        rx_byte <= {miso, rx_byte[7:1]};
    end
  end

  assign mosi = tx_sr[0];

endmodule

// File: rtl/spi_cmd_master.sv
// Host-side SPI mode-0 master: sends one opcode+payload frame per start and
// captures the bytes returned on MISO.
//
//   state  | meaning
//   IDLE   | SS high, waiting for start
//   SETUP  | SS low, bit 0 of byte 0 on MOSI before the first rising edge
//   SCK_HI | SCK high; MISO sampled on entry
//   SCK_LO | SCK low; MOSI advanced on entry
//   GAP    | SCK low, SS low, next byte on MOSI while the slave services its FIFO
//   LAST   | SS held low one half-period after the final falling edge
//   FINISH | SS high, done pulse, busy released
//   HOLD   | SS high minimum before a new start is accepted
module spi_cmd_master #(
  parameter int CLK_DIV     = 4,
  parameter int FRAME_BYTES = spi_proto_pkg::FRAME_BYTES,
  parameter int BYTE_GAP    = 16,
  parameter int SS_HOLD     = 4
) (
  input  logic               clk,
  input  logic               reset,
  spi_cmd_master_if.slave    cmd,
  output logic               SPI_SCK,
  output logic               SPI_SS,
  output logic               SPI_MOSI,
  input  logic               SPI_MISO
);
  import spi_proto_pkg::*;

  localparam int BCW = (FRAME_BYTES > 2) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(FRAME_BYTES - 1);
  localparam logic [7:0] DIV_LD  = div_load(CLK_DIV);
  localparam logic [7:0] GAP_LD  = div_load(BYTE_GAP);
  localparam logic [7:0] HOLD_LD = div_load(SS_HOLD);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] SCK_HI = 3'd2;
  localparam logic [2:0] SCK_LO = 3'd3;
  localparam logic [2:0] GAP    = 3'd4;
  localparam logic [2:0] LAST   = 3'd5;
  localparam logic [2:0] FINISH = 3'd6;
  localparam logic [2:0] HOLD   = 3'd7;

  logic [2:0]                   state;
  logic [7:0]                   div_cnt;
  logic [BCW-1:0]               byte_cnt;
  logic [8*(FRAME_BYTES-1)-1:0] pay_buf;
  logic [8*FRAME_BYTES-1:0]     rx_frame_r;
  logic                         busy_r;
  logic                         done_r;

  logic       tick;
  logic       sh_load;
  logic [7:0] sh_byte;
  logic       sh_sample;
  logic       sh_shift;
  logic [7:0] rx_byte;
  logic [2:0] bit_cnt;

  spi_byte_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (sh_load),
    .load_byte (sh_byte),
    .sample    (sh_sample),
    .shift     (sh_shift),
    .miso      (SPI_MISO),
    .mosi      (SPI_MOSI),
    .rx_byte   (rx_byte),
    .bit_cnt   (bit_cnt)
  );

  assign tick = (div_cnt == 8'd0);

  // bit_cnt is already advanced by the time SCK_LO decides, so 0 means bit 7 just went out.
  always_comb begin
    sh_load   = 1'b0;
    sh_byte   = cmd.opcode;
    sh_sample = 1'b0;
    sh_shift  = 1'b0;
    case (state)
      IDLE:   sh_load = cmd.start;
      SETUP,
      GAP:    sh_sample = tick;
      SCK_HI: sh_shift = tick;
      SCK_LO: begin
        if (tick) begin
          if (bit_cnt != 3'd0) begin
            sh_sample = 1'b1;
          end else if (byte_cnt != LAST_BYTE) begin
            sh_load = 1'b1;
            sh_byte = pay_buf[7:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= 8'd0;
      byte_cnt   <= '0;
      pay_buf    <= '0;
      rx_frame_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      SPI_SCK    <= 1'b0;
      SPI_SS     <= 1'b1;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd.start) begin
            pay_buf  <= cmd.payload;
            byte_cnt <= '0;
            busy_r   <= 1'b1;
            SPI_SS   <= 1'b0;
            div_cnt  <= DIV_LD;
            state    <= SETUP;
          end
        end
        SETUP, GAP: begin
          if (tick) begin
            SPI_SCK <= 1'b1;
            div_cnt <= DIV_LD;
            state   <= SCK_HI;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        SCK_HI: begin
          if (tick) begin
            SPI_SCK <= 1'b0;
            div_cnt <= DIV_LD;
            state   <= SCK_LO;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        SCK_LO: begin
          if (tick) begin
            if (bit_cnt != 3'd0) begin
              SPI_SCK <= 1'b1;
              div_cnt <= DIV_LD;
              state   <= SCK_HI;
            end else begin
              rx_frame_r[8*byte_cnt +: 8] <= rx_byte;
              if (byte_cnt != LAST_BYTE) begin
                byte_cnt <= byte_cnt + 1'b1;
                pay_buf  <= pay_buf >> 8;
                div_cnt  <= GAP_LD;
                state    <= GAP;
              end else begin
                div_cnt <= DIV_LD;
                state   <= LAST;
              end
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        LAST: begin
          if (tick) begin
            SPI_SS  <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state   <= FINISH;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        FINISH: begin
          div_cnt <= HOLD_LD;
          state   <= HOLD;
        end
        default: begin
          if (tick)
            state <= IDLE;
          else
            div_cnt <= div_cnt - 8'd1;
        end
      endcase
    end
  end

  assign cmd.busy     = busy_r;
  assign cmd.done     = done_r;
  assign cmd.rx_frame = rx_frame_r;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed and randomized frames against a frame-level reference of the SPI command master.
module tb_spi_cmd_master;
  import spi_proto_pkg::*;

  localparam int CLK_DIV  = 2;
  localparam int FB       = 8;
  localparam int BYTE_GAP = 4;
  localparam int SS_HOLD  = 4;
  localparam int BUSY_CYC = CLK_DIV + FB*16*CLK_DIV + (FB-1)*BYTE_GAP + CLK_DIV;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sck, ss, mosi, miso;

  spi_cmd_master_if #(.FRAME_BYTES(FB)) cmd();

  spi_cmd_master #(
    .CLK_DIV(CLK_DIV), .FRAME_BYTES(FB), .BYTE_GAP(BYTE_GAP), .SS_HOLD(SS_HOLD)
  ) dut (
    .clk(clk), .reset(reset), .cmd(cmd),
    .SPI_SCK(sck), .SPI_SS(ss), .SPI_MOSI(mosi), .SPI_MISO(miso)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int busy_cyc = 0, done_cnt = 0, sck_rise = 0, ss_fall = 0;
  int ss_hi_busy = 0, sck_hi_ss = 0;
  int ss_run = 0, min_hold = 1000;
  logic prev_sck = 1'b0, prev_ss = 1'b1;
  logic mosi_q[$];

  // Behavioural slave: presents slave_frame LSB-first, first bit on SS fall, next bit on each SCK fall.
  logic        loop_mode = 1'b1;
  logic [63:0] slave_frame = '0;
  int          sidx = 0;
  logic        slave_bit = 1'b0;
  assign miso = loop_mode ? mosi : slave_bit;

  always @(negedge clk) begin
    if (cmd.busy) busy_cyc++;
    if (cmd.done) done_cnt++;
    if (sck && !prev_sck) begin
      sck_rise++;
      mosi_q.push_back(mosi);
    end
    if (sck && ss) sck_hi_ss++;
    if (cmd.busy && ss) ss_hi_busy++;
    if (!ss && prev_ss) begin
      ss_fall++;
      if (ss_run < min_hold) min_hold = ss_run;
      sidx = 0;
    end
    if (!sck && prev_sck) sidx++;
    ss_run = ss ? ss_run + 1 : 0;
    slave_bit = (sidx < 64) ? slave_frame[sidx] : 1'b0;
    prev_sck = sck;
    prev_ss  = ss;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue_start(input logic [7:0] op, input logic [55:0] pl, input string tag);
    bit got;
    cmd.opcode  = op;
    cmd.payload = pl;
    cmd.start   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = cmd.busy;
    end
    cmd.start = 1'b0;
    check({tag, "_accept"}, 64'(got), 64'd1);
  endtask

  task automatic run_frame(input logic [7:0] op, input logic [55:0] pl, input logic lb,
                           input logic [63:0] sf, input bit inj, input string tag);
    int b0, d0, r0, f0, h0, s0;
    logic [63:0] frame, got;
    bit seen;
    frame = {pl, op};
    loop_mode = lb;
    slave_frame = sf;
    mosi_q.delete();
    b0 = busy_cyc; d0 = done_cnt; r0 = sck_rise; f0 = ss_fall; h0 = ss_hi_busy; s0 = sck_hi_ss;
    issue_start(op, pl, tag);
    if (inj) begin
      repeat (49) @(negedge clk);
      cmd.opcode = ~op;
      cmd.start  = 1'b1;
      @(negedge clk);
      cmd.start  = 1'b0;
      cmd.opcode = op;
    end
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      seen = cmd.done;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    repeat (2) @(negedge clk);
    check({tag, "_rx_frame"}, cmd.rx_frame, lb ? frame : sf);
    got = '0;
    for (int i = 0; i < mosi_q.size() && i < 64; i++) got[i] = mosi_q[i];
    check({tag, "_mosi_bits"}, got, frame);
    check({tag, "_mosi_first_byte"}, 64'(got[7:0]), 64'(op));
    check({tag, "_busy_cycles"}, 64'(busy_cyc - b0), 64'(BUSY_CYC));
    check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_sck_rises"}, 64'(sck_rise - r0), 64'(8*FB));
    check({tag, "_ss_falls"}, 64'(ss_fall - f0), 64'd1);
    check({tag, "_ss_high_in_frame"}, 64'(ss_hi_busy - h0), 64'd0);
    check({tag, "_sck_high_ss_high"}, 64'(sck_hi_ss - s0), 64'd0);
  endtask

  initial begin : main
    logic [63:0] sf;
    logic [55:0] pl;
    int d0, r0;
    bit hit;
    cmd.start   = 1'b0;
    cmd.opcode  = '0;
    cmd.payload = '0;

    repeat (3) @(negedge clk);
    check("rst_ss", 64'(ss), 64'd1);
    check("rst_sck", 64'(sck), 64'd0);
    check("rst_mosi", 64'(mosi), 64'd0);
    check("rst_busy", 64'(cmd.busy), 64'd0);
    check("rst_done", 64'(cmd.done), 64'd0);
    check("rst_rx_frame", cmd.rx_frame, 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    run_frame(OP_WR_INVERTED, 56'h00000000000AA5, 1'b1, 64'd0, 1'b1, "loopback_ignored_start");
    run_frame(OP_INIT, 56'd0, 1'b1, 64'd0, 1'b0, "bit_order");
    sf = 64'h0A09080706050440;
    run_frame(OP_RD_VEC, 56'h123456789ABCDE, 1'b0, sf, 1'b0, "slave_echo");
    check("slave_echo_byte0", 64'(cmd.rx_frame[7:0]), 64'(ECHO_MARKER));
    check("slave_echo_byte1", 64'(cmd.rx_frame[15:8]), 64'h04);

    for (int k = 0; k < 4; k++) begin
      pl = 56'({$urandom, $urandom});
      sf = {$urandom, $urandom};
      run_frame(8'($urandom), pl, 1'($urandom), sf, 1'b0, $sformatf("rand%0d", k));
    end

    repeat (SS_HOLD + 4) @(negedge clk);
    loop_mode = 1'b1;
    d0 = done_cnt;
    r0 = sck_rise;
    issue_start(OP_WR_VEC, 56'hFFEEDDCCBBAA99, "reset_mid");
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      hit = (sck_rise - r0) >= 27;
    end
    check("reset_mid_reached_byte3", 64'(hit), 64'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("reset_mid_ss", 64'(ss), 64'd1);
    check("reset_mid_sck", 64'(sck), 64'd0);
    check("reset_mid_busy", 64'(cmd.busy), 64'd0);
    check("reset_mid_rx_frame", cmd.rx_frame, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("reset_mid_no_done", 64'(done_cnt - d0), 64'd0);
    run_frame(OP_WR_LEDS, 56'h0102030405060F, 1'b1, 64'd0, 1'b0, "after_reset");

    check("ss_hold_min", 64'(min_hold >= SS_HOLD), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
